hps_fpga_button_debounce: RTL and testbench
===========================================

HPS_FPGA_BUTTON_DEBOUNCE -- requirements
Module: hps_fpga_button_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of button channels.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per debounce tick (1 ms at 50 MHz); legal range >= 1.
REQ-003 Parameter STABLE_TICKS, default 10: consecutive ticks of stable mismatching input required to commit a change; legal range >= 1.
REQ-004 Parameter RELEASED_LEVEL, default 1: idle (released) logic level of every button; buttons are active-low by default.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 button_in  in  WIDTH  raw asynchronous button pins.
REQ-008 button_out  out  WIDTH  debounced button levels, registered; this bus drives the PIO in_port.
REQ-009 press_pulse  out  WIDTH  one-cycle strobe per channel when button_out enters the pressed level.
REQ-010 release_pulse  out  WIDTH  one-cycle strobe per channel when button_out returns to RELEASED_LEVEL.
REQ-011 all_stable  out  1  high when every channel is in state IDLE.

Function
REQ-012 Each button_in bit SHALL pass through a 2-flop synchronizer; sync output = input delayed 2 clk cycles.
REQ-013 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick is high for exactly the cycle in which the count equals TICK_DIV-1; with TICK_DIV=1, tick is high every cycle.
REQ-014 Each channel SHALL run a 2-state FSM (IDLE, PENDING) with a tick counter of width clog2(STABLE_TICKS+1).
REQ-015 IDLE: if sync != button_out, go to PENDING and clear the counter; otherwise stay with the counter at 0.
REQ-016 PENDING, sync == button_out (bounce back): return to IDLE, clear the counter, leave button_out unchanged, emit no pulse.
REQ-017 PENDING, sync != button_out, tick high, counter == STABLE_TICKS-1: load button_out <= sync, go to IDLE, clear the counter.
REQ-018 PENDING, sync != button_out, tick high, counter < STABLE_TICKS-1: increment the counter; with tick low: hold.
REQ-019 press_pulse[i] and release_pulse[i] SHALL be registered and high in the same cycle button_out[i] first shows its new value, for exactly one cycle; they SHALL never both be high for one channel.
REQ-020 Latency with TICK_DIV=1: button_out changes N+3 cycles after a clean input edge, where N = STABLE_TICKS.
REQ-021 Bounce rule: the bounce-back check (REQ-016) SHALL take priority over the tick check in the same cycle.
REQ-022 Channels SHALL be fully independent; simultaneous changes on several channels each follow REQ-015..REQ-019 with no interaction.
REQ-023 The prescaler SHALL run freely and SHALL NOT be restarted by channel activity.

Reset
REQ-024 While reset is high at a clk edge: synchronizer flops and button_out = {WIDTH{RELEASED_LEVEL}}; prescaler = 0; counters = 0; FSMs = IDLE; press_pulse = release_pulse = 0; all_stable = 1.
REQ-025 Reset asserted mid-PENDING SHALL abandon the pending change with no pulse emitted.
REQ-026 After reset deasserts, a button held pressed SHALL be reported as a normal press after the REQ-020 latency.

Structure
REQ-027 Package hps_fpga_button_pkg SHALL hold the FSM state enum (IDLE, PENDING) and the default values of TICK_DIV, STABLE_TICKS and RELEASED_LEVEL.
REQ-028 The per-channel FSM, counter and pulse logic SHALL be a sub-module hps_fpga_debounce_chan, instantiated WIDTH times in a generate loop; the synchronizer and prescaler SHALL stay in the top level.

Verification (TICK_DIV=1, STABLE_TICKS=4, WIDTH=4 unless stated)
REQ-029 Clean press: button_in[0] 1->0 at cycle 0 and held -> button_out[0]=0 and press_pulse[0]=1 at cycle 7, for one cycle only.
REQ-030 Bounce: button_in[1] low for 3 cycles then high -> button_out[1] stays 1, no pulses, all_stable returns to 1.
REQ-031 Release: after REQ-029, button_in[0] 0->1 held -> button_out[0]=1 and release_pulse[0]=1 exactly 7 cycles later.
REQ-032 Prescaler: TICK_DIV=5, STABLE_TICKS=2, clean press on channel 2 -> the change commits only on tick edges; check that the latency is between 7 and 14 cycles and the pulse width is 1.
REQ-033 Reset mid-PENDING: press channel 3, assert reset for 1 cycle at cycle 5 -> button_out=4'hF, no pulse, then press reported 7 cycles after reset release.
REQ-034 Simultaneous: channels 0 and 3 pressed in the same cycle -> both press_pulse bits high in the same cycle (cycle 7); channels 1 and 2 untouched.

Source files
------------

// File: rtl/hps_fpga_button_debounce_pkg.sv
// Shared types and defaults for the HPS/FPGA button debouncer.
// Holds the channel FSM state enum, parameter defaults and a width helper.
package hps_fpga_button_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } chan_state_e;

   // 1 ms debounce tick at 50 MHz
   localparam int unsigned DEF_TICK_DIV       = 50000;
   localparam int unsigned DEF_STABLE_TICKS   = 10;
   // Buttons idle high (active-low pins)
   localparam bit          DEF_RELEASED_LEVEL = 1'b1;

   // Bits needed for values 0..n-1, never less than one bit
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hps_fpga_button_debounce_if.sv
// Button bus between the pins side (master) and the debouncer (slave).
// button_in: raw pins; button_out/press_pulse/release_pulse/all_stable: results.
interface hps_fpga_button_debounce_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] button_in;
   logic [WIDTH-1:0] button_out;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;
   logic             all_stable;

   modport master (
      output button_in,
      input  button_out,
      input  press_pulse,
      input  release_pulse,
      input  all_stable
   );

   modport slave (
      input  button_in,
      output button_out,
      output press_pulse,
      output release_pulse,
      output all_stable
   );

endinterface

// File: rtl/hps_fpga_button_debounce_chan.sv
// One debounce channel: IDLE/PENDING FSM, stable-tick counter, edge pulses.
// Ports: clk, reset, sync_i (synchronised pin), tick_i (prescaler strobe),
//        btn_o (debounced level), press_o/release_o (1-cycle strobes), idle_o.
module hps_fpga_debounce_chan
   import hps_fpga_button_pkg::*;
#(
   parameter int unsigned STABLE_TICKS   = DEF_STABLE_TICKS,
   parameter bit          RELEASED_LEVEL = DEF_RELEASED_LEVEL
) (
   input  logic clk,
   input  logic reset,
   input  logic sync_i,
   input  logic tick_i,
   output logic btn_o,
   output logic press_o,
   output logic release_o,
   output logic idle_o
);

   localparam int unsigned CW = safe_clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   chan_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic          btn_q;
   logic          press_q;
   logic          rel_q;
   logic          differ;

   assign differ = (sync_i != btn_q);

   // The bounce-back test comes before the tick test, so an input that
   // returns to the committed level always aborts, even on a tick cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         btn_q   <= RELEASED_LEVEL;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (differ) begin
                  state_q <= PENDING;
               end
            end
            PENDING: begin
               if (!differ) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (tick_i) begin
                  if (cnt_q == CNT_LAST) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     btn_q   <= sync_i;
                     press_q <= (sync_i != RELEASED_LEVEL);
                     rel_q   <= (sync_i == RELEASED_LEVEL);
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_o     = btn_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign idle_o    = (state_q == IDLE);

endmodule

// File: rtl/hps_fpga_button_debounce.sv
// Debouncer for WIDTH raw button pins feeding an HPS PIO in_port.
// Ports: clk, reset (sync, active-high), bus (slave modport: button_in in;
//        button_out, press_pulse, release_pulse, all_stable out).
module hps_fpga_button_debounce
   import hps_fpga_button_pkg::*;
#(
   parameter int unsigned WIDTH          = 4,
   parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
   parameter int unsigned STABLE_TICKS   = DEF_STABLE_TICKS,
   parameter bit          RELEASED_LEVEL = DEF_RELEASED_LEVEL
) (
   input logic                        clk,
   input logic                        reset,
   hps_fpga_button_debounce_if.slave  bus
);

   localparam int unsigned PW = safe_clog2(TICK_DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [PW-1:0]    ps_q;
   logic [PW-1:0]    ps_d;
   logic             tick;

   logic [WIDTH-1:0] btn_w;
   logic [WIDTH-1:0] press_w;
   logic [WIDTH-1:0] rel_w;
   logic [WIDTH-1:0] idle_w;

   // Two-flop synchroniser; resets to the released level so that a
   // button held through reset is seen as a fresh press afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= {WIDTH{RELEASED_LEVEL}};
         sync_q <= {WIDTH{RELEASED_LEVEL}};
      end else begin
         meta_q <= bus.button_in;
         sync_q <= meta_q;
      end
   end

   // Free-running prescaler shared by all channels; never restarted by
   // channel activity, so commit timing depends on prescaler phase.
   assign tick = (ps_q == PS_LAST);
   assign ps_d = tick ? '0 : ps_q + PW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      hps_fpga_debounce_chan #(
         .STABLE_TICKS   (STABLE_TICKS),
         .RELEASED_LEVEL (RELEASED_LEVEL)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .sync_i    (sync_q[g]),
         .tick_i    (tick),
         .btn_o     (btn_w[g]),
         .press_o   (press_w[g]),
         .release_o (rel_w[g]),
         .idle_o    (idle_w[g])
      );
   end

   assign bus.button_out    = btn_w;
   assign bus.press_pulse   = press_w;
   assign bus.release_pulse = rel_w;
   assign bus.all_stable    = &idle_w;

endmodule

// File: tb/tb_hps_fpga_button_debounce.sv
// Bench for hps_fpga_button_debounce: two instances (fast tick, prescaled).
// Reference model predicts commits; monitor checks pulses and levels.
module tb_hps_fpga_button_debounce;

   localparam int W    = 4;
   localparam int TD_A = 1;
   localparam int NS_A = 4;
   localparam int TD_B = 5;
   localparam int NS_B = 2;

   typedef struct {
      int d;
      int ch;
      bit press;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   hps_fpga_button_debounce_if #(.WIDTH(W)) bus_a ();
   hps_fpga_button_debounce_if #(.WIDTH(W)) bus_b ();

   hps_fpga_button_debounce #(
      .WIDTH(W), .TICK_DIV(TD_A), .STABLE_TICKS(NS_A), .RELEASED_LEVEL(1'b1)
   ) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a.slave)
   );

   hps_fpga_button_debounce #(
      .WIDTH(W), .TICK_DIV(TD_B), .STABLE_TICKS(NS_B), .RELEASED_LEVEL(1'b1)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Pin seen by the debouncer = pin two edges earlier. A mismatch window
   // opens on the first edge the synced pin differs from the output; it
   // closes on any matching edge, and commits once N prescaler ticks have
   // fallen strictly after the opening edge. Ticks are counted by
   // arithmetic on the edge index since reset.
   logic [W-1:0] m_s1 [2];
   logic [W-1:0] m_s2 [2];
   logic [W-1:0] m_out [2];
   int           m_win [2][W];
   int           m_j [2];
   bit           m_stable [2];

   function automatic int td(input int d);
      return (d == 0) ? TD_A : TD_B;
   endfunction

   function automatic int ns(input int d);
      return (d == 0) ? NS_A : NS_B;
   endfunction

   task automatic model_step(input int d, input logic rst,
                             input logic [W-1:0] pin);
      int   tk;
      ev_t  e;
      logic sv;
      if (rst) begin
         m_s1[d]  = '1;
         m_s2[d]  = '1;
         m_out[d] = '1;
         m_j[d]   = 0;
         for (int ch = 0; ch < W; ch++) m_win[d][ch] = -1;
      end else begin
         for (int ch = 0; ch < W; ch++) begin
            sv = m_s2[d][ch];
            if (m_win[d][ch] >= 0) begin
               if (sv == m_out[d][ch]) begin
                  m_win[d][ch] = -1;
               end else begin
                  tk = (m_j[d] + 1) / td(d) - (m_win[d][ch] + 1) / td(d);
                  if (tk == ns(d)) begin
                     m_out[d][ch] = sv;
                     m_win[d][ch] = -1;
                     e.d     = d;
                     e.ch    = ch;
                     e.press = (sv == 1'b0);
                     e.cyc   = cyc;
                     exp_q.push_back(e);
                  end
               end
            end else if (sv != m_out[d][ch]) begin
               m_win[d][ch] = m_j[d];
            end
         end
         m_j[d]++;
         m_s2[d] = m_s1[d];
         m_s1[d] = pin;
      end
      m_stable[d] = 1'b1;
      for (int ch = 0; ch < W; ch++)
         if (m_win[d][ch] >= 0) m_stable[d] = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step(0, rst_a, bus_a.button_in);
         model_step(1, rst_b, bus_b.button_in);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      ev_t          e;
      logic [W-1:0] o;
      logic [W-1:0] pp;
      logic [W-1:0] rp;
      logic         st;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            o  = (d == 0) ? bus_a.button_out    : bus_b.button_out;
            pp = (d == 0) ? bus_a.press_pulse   : bus_b.press_pulse;
            rp = (d == 0) ? bus_a.release_pulse : bus_b.release_pulse;
            st = (d == 0) ? bus_a.all_stable    : bus_b.all_stable;
            chk($sformatf("button_out_d%0d", d), 32'(o), 32'(m_out[d]));
            chk($sformatf("all_stable_d%0d", d), 32'(st), 32'(m_stable[d]));
            for (int ch = 0; ch < W; ch++) begin
               if (pp[ch] || rp[ch]) begin
                  chk("pulse_exclusive", 32'(pp[ch] & rp[ch]), 0);
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_pulse: dut %0d ch %0d got pulse want none (cycle %0d)",
                              d, ch, cyc);
                  end else begin
                     e = exp_q.pop_front();
                     chk("pulse_where", 32'(d * W + ch), 32'(e.d * W + e.ch));
                     chk("pulse_kind", 32'(pp[ch]), 32'(e.press));
                     chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                  end
               end
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_pulse: dut %0d ch %0d got none want pulse at cycle %0d",
                     e.d, e.ch, e.cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_pulse(input int d, input int ch, input bit press,
                             output int lat);
      logic [W-1:0] v;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (d == 0) v = press ? bus_a.press_pulse : bus_a.release_pulse;
         else        v = press ? bus_b.press_pulse : bus_b.release_pulse;
         if (v[ch]) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int           lat;
      logic [W-1:0] v;
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.button_in = '1;
      bus_b.button_in = '1;
      repeat (3) @(negedge clk);
      chk("rst_out_a", 32'(bus_a.button_out), 32'hF);
      chk("rst_press_a", 32'(bus_a.press_pulse), 0);
      chk("rst_release_a", 32'(bus_a.release_pulse), 0);
      chk("rst_stable_a", 32'(bus_a.all_stable), 1);
      chk("rst_out_b", 32'(bus_b.button_out), 32'hF);
      chk("rst_stable_b", 32'(bus_b.all_stable), 1);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (5) @(negedge clk);

      // clean press then release on channel 0
      bus_a.button_in[0] = 1'b0;
      wait_pulse(0, 0, 1'b1, lat);
      chk("press_latency", 32'(lat), 7);
      chk("press_level", 32'(bus_a.button_out[0]), 0);
      @(negedge clk);
      chk("press_width", 32'(bus_a.press_pulse[0]), 0);
      repeat (4) @(negedge clk);
      bus_a.button_in[0] = 1'b1;
      wait_pulse(0, 0, 1'b0, lat);
      chk("release_latency", 32'(lat), 7);
      chk("release_level", 32'(bus_a.button_out[0]), 1);
      @(negedge clk);
      chk("release_width", 32'(bus_a.release_pulse[0]), 0);

      // three-cycle bounce on channel 1
      bus_a.button_in[1] = 1'b0;
      repeat (3) @(negedge clk);
      bus_a.button_in[1] = 1'b1;
      v = '0;
      repeat (15) begin
         @(negedge clk);
         v = v | bus_a.press_pulse | bus_a.release_pulse;
      end
      chk("bounce_no_pulse", 32'(v[1]), 0);
      chk("bounce_level", 32'(bus_a.button_out[1]), 1);
      chk("bounce_stable", 32'(bus_a.all_stable), 1);

      // channels 0 and 3 pressed together
      bus_a.button_in = 4'b0110;
      wait_pulse(0, 0, 1'b1, lat);
      chk("simul_latency", 32'(lat), 7);
      chk("simul_pulses", 32'(bus_a.press_pulse), 32'h9);
      chk("simul_level", 32'(bus_a.button_out), 32'h6);
      repeat (3) @(negedge clk);
      bus_a.button_in = '1;
      repeat (12) @(negedge clk);

      // reset in the middle of a pending press on channel 3
      bus_a.button_in[3] = 1'b0;
      repeat (4) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk("rst_mid_level", 32'(bus_a.button_out), 32'hF);
      chk("rst_mid_pulse", 32'(bus_a.press_pulse), 0);
      wait_pulse(0, 3, 1'b1, lat);
      chk("rst_mid_latency", 32'(lat), 7);
      bus_a.button_in[3] = 1'b1;
      repeat (12) @(negedge clk);

      // prescaled instance: commit aligned to tick edges
      bus_b.button_in[2] = 1'b0;
      wait_pulse(1, 2, 1'b1, lat);
      chk("presc_latency_ok", 32'(lat >= 7 && lat <= 14), 1);
      @(negedge clk);
      chk("presc_width", 32'(bus_b.press_pulse[2]), 0);
      bus_b.button_in[2] = 1'b1;
      repeat (20) @(negedge clk);

      // random bouncing on every channel of both instances
      repeat (800) begin
         @(negedge clk);
         rst_a = ($urandom_range(0, 249) == 0);
         for (int ch = 0; ch < W; ch++) begin
            if ($urandom_range(0, 9) == 0)
               bus_a.button_in[ch] = ~bus_a.button_in[ch];
            if ($urandom_range(0, 17) == 0)
               bus_b.button_in[ch] = ~bus_b.button_in[ch];
         end
      end
      rst_a = 1'b0;
      bus_a.button_in = '1;
      bus_b.button_in = '1;
      repeat (40) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
